hams_merge_ctrl: RTL and testbench
==================================

Name: hams_merge_ctrl

Overview:
- Sequencing controller for the HAMS merge stage.
- Drains two sorted input runs, A and B, from two upstream synchronous FIFOs and writes one merged, sorted run into a downstream synchronous FIFO.
- Drives the FIFO pop and push strobes directly.
- Moves at most one element per cycle, taking data from each input FIFO's combinational head (pop_data).

Parameters:
- DATA_WIDTH, 8, element width; matches the FIFO_WIDTH of attached FIFOs.
- LEN_W, 16, width of run-length and remaining-element counters.
- DESCENDING, 0, 0 = ascending merge (smaller element first); 1 = descending (larger element first).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begin a merge of two runs of length run_len
- run_len  in  LEN_W  elements per input run; sampled only on an accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the merged run is complete
- a_empty  in  1  FIFO A empty
- a_data  in  DATA_WIDTH  FIFO A head element
- a_pop  out  1  pop FIFO A
- b_empty  in  1  FIFO B empty
- b_data  in  DATA_WIDTH  FIFO B head element
- b_pop  out  1  pop FIFO B
- out_full  in  1  output FIFO full
- out_data  out  DATA_WIDTH  element pushed to the output FIFO
- out_push  out  1  push to the output FIFO
- out_count  out  LEN_W+1  elements emitted in the current or last merge

Behaviour:
- Reset values:
  - state = IDLE.
  - busy, done, a_pop, b_pop, out_push = 0.
  - out_data = 0; out_count = 0.
  - Internal counters rem_a = rem_b = 0.
- Reset mid-merge: abort immediately to IDLE. FIFO contents are not touched; flushing them is the system's job.
- States: IDLE, MERGE, DRAIN_A, DRAIN_B, DONE. One state register plus rem_a/rem_b, each LEN_W bits.
- IDLE:
  - On start: rem_a = rem_b = run_len, out_count = 0.
  - Next state: MERGE if run_len != 0, else DONE.
  - start is ignored in every state other than IDLE.
- MERGE:
  - Transfer occurs only when !a_empty && !b_empty && !out_full.
  - Selection: pick A if a_data <= b_data (ascending) or a_data >= b_data (descending), else pick B. Ties always select A, so the merge is stable.
  - Comparison is unsigned.
  - On transfer, in the same cycle: pop the selected FIFO, out_push = 1, out_data = selected head. Decrement that rem counter and increment out_count.
  - If the decremented counter reaches 0, go to DRAIN_B (A exhausted) or DRAIN_A (B exhausted).
  - Otherwise wait, holding all strobes at 0.
- DRAIN_A / DRAIN_B:
  - Transfer from the remaining FIFO when it is not empty and !out_full.
  - Transfer with rem == 1 -> DONE.
- DONE: done = 1 for exactly one cycle, busy = 0, then IDLE. A start in the DONE cycle is ignored.
- out_push, out_data, a_pop and b_pop are combinational from state, the counters and the FIFO flags.
  - Latency from FIFO head to output push is 0 cycles.
  - out_data is don't-care when out_push = 0; drive the selected head.
- Strobe rules:
  - Never pop an empty FIFO.
  - Never push when out_full.
  - a_pop and b_pop are never both high.
  - out_push == (a_pop | b_pop) at all times.
- busy is registered: 1 in MERGE, DRAIN_A and DRAIN_B.
- out_count holds its final value until the next accepted start.
- Throughput: 1 element per cycle when no stalls occur. 2N elements complete in 2N cycles after start, plus 1 cycle for DONE.

Decomposition:
- Package hams_pkg holds:
  - typedef enum logic [2:0] hams_merge_state_e {IDLE, MERGE, DRAIN_A, DRAIN_B, DONE}.
  - localparam HAMS_DATA_W = 8, shared with the FIFO instances.
- Sub-module hams_merge_sel is natural: a combinational comparator and mux taking a_data, b_data and DESCENDING, and producing sel_a and the selected data.
- The controller contains the FSM and the counters only.
- The test bench wraps the controller with three hams_syncfifo instances (A, B, OUT), each FIFO_DEPTH 16 and FIFO_WIDTH 8.

Test Plan:
- Basic ascending merge:
  - Stimulus: A = {1,4,7,9}, B = {2,3,8,10}, start with run_len = 4, no stalls.
  - Response: OUT = {1,2,3,4,7,8,9,10}; done 9 cycles after start; out_count = 8; busy high for 8 cycles.
- Ties and stability:
  - Stimulus: A = {5,5}, B = {5,6}, run_len = 2.
  - Response: first three pops come from A, A, B, then B; OUT = {5,5,5,6}.
- Exhaust and drain:
  - Stimulus: A = {1,2,3}, B = {10,11,12}, run_len = 3.
  - Response: after 3 A pops, state is DRAIN_B; OUT = {1,2,3,10,11,12}; no a_pop after the 3rd cycle.
- Back-pressure and starvation:
  - Stimulus: out_full held high for 5 cycles mid-merge; later b_empty held high for 3 cycles.
  - Response: zero strobes during both stalls; final OUT sequence still sorted and complete; no push while full.
- Descending mode and zero length:
  - Stimulus: DESCENDING = 1 with A = {9,6}, B = {8,2}.
  - Response: OUT = {9,8,6,2}.
  - Stimulus: run_len = 0.
  - Response: done 1 cycle after start; no pops.
- Reset and ignored start:
  - Stimulus: rst_n low mid-merge after 3 transfers.
  - Response: all strobes 0 asynchronously, state IDLE, out_count = 0.
  - Stimulus: a start pulse while busy.
  - Response: no effect on rem counters or output.

Source files
------------

// File: rtl/hams_pkg.sv
// -----------------------------------------------------------------------------
// hams_pkg
// Shared types and constants for the HAMS merge stage.
//   hams_merge_state_e : state encoding of the merge sequencing controller
//   HAMS_DATA_W        : element width shared by the merge controller and the
//                        FIFO instances that feed and drain it
//   HAMS_FIFO_DEPTH    : depth of the FIFOs around the merge stage
// -----------------------------------------------------------------------------
package hams_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MERGE   = 3'd1,
    DRAIN_A = 3'd2,
    DRAIN_B = 3'd3,
    DONE    = 3'd4
  } hams_merge_state_e;

  localparam int HAMS_DATA_W     = 8;
  localparam int HAMS_FIFO_DEPTH = 16;

endpackage : hams_pkg

// File: rtl/hams_merge_sel.sv
// -----------------------------------------------------------------------------
// hams_merge_sel
// Comparator and mux choosing which run head goes out next.
// Ports:
//   a_data_i, b_data_i : heads of runs A and B (unsigned)
//   sel_a_o            : 1 when A's head should be emitted
//   sel_data_o         : the chosen head
// Parameter DESCENDING picks the larger element first instead of the smaller.
// Equal heads always choose A, which keeps the merge stable.
// -----------------------------------------------------------------------------
module hams_merge_sel #(
  parameter int DATA_WIDTH = 8,
  parameter bit DESCENDING = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  sel_a_o,
  output logic [DATA_WIDTH-1:0] sel_data_o
);

  always_comb begin
    if (DESCENDING) begin
      sel_a_o = (a_data_i >= b_data_i);
    end else begin
      sel_a_o = (a_data_i <= b_data_i);
    end
    sel_data_o = sel_a_o ? a_data_i : b_data_i;
  end

endmodule : hams_merge_sel

// File: rtl/hams_syncfifo.sv
// -----------------------------------------------------------------------------
// hams_syncfifo
// Single-clock FIFO with a combinational head (pop_data shows the oldest
// element whenever empty is low). Pushes while full and pops while empty are
// ignored. FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write strobe and element
//   pop                : read strobe, consumes the head element
//   pop_data           : current head element
//   empty, full        : occupancy flags
// -----------------------------------------------------------------------------
module hams_syncfifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [FIFO_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop_data = mem_q[rd_ptr_q];

  // Storage is not reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : hams_syncfifo

// File: rtl/hams_merge_ctrl.sv
// -----------------------------------------------------------------------------
// hams_merge_ctrl
// Sequencing controller for the HAMS merge stage. Drains two sorted runs of
// equal length from FIFOs A and B and pushes one merged sorted run into the
// output FIFO, at most one element per cycle, straight from the FIFO heads.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, run_len      : start pulse and per-run length (sampled in IDLE)
//   busy, done          : merge in progress / one-cycle completion pulse
//   a_empty/a_data/a_pop: FIFO A flag, head and pop strobe
//   b_empty/b_data/b_pop: FIFO B flag, head and pop strobe
//   out_full/out_data/out_push : output FIFO flag, element and push strobe
//   out_count           : elements emitted by the current or last merge
// -----------------------------------------------------------------------------
module hams_merge_ctrl
  import hams_pkg::*;
#(
  parameter int          DATA_WIDTH = HAMS_DATA_W,
  parameter int unsigned LEN_W      = 16,
  parameter bit          DESCENDING = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      run_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  a_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_pop,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_pop,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_push,
  output logic [LEN_W:0]        out_count
);

  hams_merge_state_e state_q, state_d;
  logic [LEN_W-1:0]  rem_a_q, rem_a_d;
  logic [LEN_W-1:0]  rem_b_q, rem_b_d;
  logic [LEN_W:0]    count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sel_a;
  logic [DATA_WIDTH-1:0] sel_data;

  hams_merge_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .DESCENDING (DESCENDING)
  ) u_sel (
    .a_data_i   (a_data),
    .b_data_i   (b_data),
    .sel_a_o    (sel_a),
    .sel_data_o (sel_data)
  );

  // Next-state, counter updates and the FIFO strobes. The strobes are purely
  // combinational so a head element reaches the output FIFO in the same cycle
  // it is popped. A merge cannot finish directly from MERGE: when one run runs
  // out the other still has at least one element, so it always passes through
  // a drain state.
  always_comb begin
    state_d  = state_q;
    rem_a_d  = rem_a_q;
    rem_b_d  = rem_b_q;
    count_d  = count_q;
    a_pop    = 1'b0;
    b_pop    = 1'b0;
    out_data = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_a_d = run_len;
          rem_b_d = run_len;
          count_d = '0;
          state_d = (run_len != '0) ? MERGE : DONE;
        end
      end

      MERGE: begin
        out_data = sel_data;
        if (!a_empty && !b_empty && !out_full) begin
          count_d = count_q + (LEN_W+1)'(1);
          if (sel_a) begin
            a_pop   = 1'b1;
            rem_a_d = rem_a_q - LEN_W'(1);
            if (rem_a_q == LEN_W'(1)) begin
              state_d = DRAIN_B;
            end
          end else begin
            b_pop   = 1'b1;
            rem_b_d = rem_b_q - LEN_W'(1);
            if (rem_b_q == LEN_W'(1)) begin
              state_d = DRAIN_A;
            end
          end
        end
      end

      DRAIN_A: begin
        out_data = a_data;
        if (!a_empty && !out_full) begin
          a_pop   = 1'b1;
          rem_a_d = rem_a_q - LEN_W'(1);
          count_d = count_q + (LEN_W+1)'(1);
          if (rem_a_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DRAIN_B: begin
        out_data = b_data;
        if (!b_empty && !out_full) begin
          b_pop   = 1'b1;
          rem_b_d = rem_b_q - LEN_W'(1);
          count_d = count_q + (LEN_W+1)'(1);
          if (rem_b_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MERGE) || (state_d == DRAIN_A) || (state_d == DRAIN_B);
    done_d = (state_d == DONE);
  end

  assign out_push  = a_pop | b_pop;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_count = count_q;

  // State and counters; reset aborts any merge in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_a_q <= '0;
      rem_b_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_a_q <= rem_a_d;
      rem_b_q <= rem_b_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule : hams_merge_ctrl

// File: tb/tb_hams_merge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hams_merge_ctrl
// Two merge controllers (ascending and descending), each wrapped by input
// FIFOs A and B and an output FIFO. Directed runs with hand-computed merged
// sequences, latencies and counts.
// -----------------------------------------------------------------------------
module tb_hams_merge_ctrl;
  import hams_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  // Ascending controller and its FIFOs
  logic        start, busy, done;
  logic [15:0] runLen;
  logic        aPop, bPop, outPush;
  logic [7:0]  aData, bData, outData;
  logic [16:0] outCount;
  logic        aEmptyF, bEmptyF, outFullF, aFull, bFull;
  logic        aEmpty, bEmpty, outFull;
  logic        forceFull, forceBEmpty;
  logic [7:0]  outHead;
  logic        outEmpty;

  // Descending controller and its FIFOs
  logic        start2, busy2, done2;
  logic        a2Pop, b2Pop, out2Push;
  logic [7:0]  a2Data, b2Data, out2Data;
  logic [16:0] out2Count;
  logic        a2Empty, b2Empty, out2Full, a2Full, b2Full;
  logic [7:0]  out2Head;
  logic        out2Empty;

  logic        tbPushA, tbPushB, tbPushA2, tbPushB2;
  logic [7:0]  tbDataA, tbDataB;

  assign aEmpty  = aEmptyF;
  assign bEmpty  = bEmptyF | forceBEmpty;
  assign outFull = outFullF | forceFull;

  hams_syncfifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(8)) uFifoA (
    .clk(clk), .rst_n(rstN), .push(tbPushA), .push_data(tbDataA), .pop(aPop),
    .pop_data(aData), .empty(aEmptyF), .full(aFull));
  hams_syncfifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(8)) uFifoB (
    .clk(clk), .rst_n(rstN), .push(tbPushB), .push_data(tbDataB), .pop(bPop),
    .pop_data(bData), .empty(bEmptyF), .full(bFull));
  hams_syncfifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(8)) uFifoOut (
    .clk(clk), .rst_n(rstN), .push(outPush), .push_data(outData), .pop(1'b0),
    .pop_data(outHead), .empty(outEmpty), .full(outFullF));

  hams_merge_ctrl #(.DATA_WIDTH(8), .LEN_W(16), .DESCENDING(1'b0)) dut (
    .clk(clk), .rst_n(rstN), .start(start), .run_len(runLen), .busy(busy),
    .done(done), .a_empty(aEmpty), .a_data(aData), .a_pop(aPop),
    .b_empty(bEmpty), .b_data(bData), .b_pop(bPop), .out_full(outFull),
    .out_data(outData), .out_push(outPush), .out_count(outCount));

  hams_syncfifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(8)) uFifoA2 (
    .clk(clk), .rst_n(rstN), .push(tbPushA2), .push_data(tbDataA), .pop(a2Pop),
    .pop_data(a2Data), .empty(a2Empty), .full(a2Full));
  hams_syncfifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(8)) uFifoB2 (
    .clk(clk), .rst_n(rstN), .push(tbPushB2), .push_data(tbDataB), .pop(b2Pop),
    .pop_data(b2Data), .empty(b2Empty), .full(b2Full));
  hams_syncfifo #(.FIFO_DEPTH(16), .FIFO_WIDTH(8)) uFifoOut2 (
    .clk(clk), .rst_n(rstN), .push(out2Push), .push_data(out2Data), .pop(1'b0),
    .pop_data(out2Head), .empty(out2Empty), .full(out2Full));

  hams_merge_ctrl #(.DATA_WIDTH(8), .LEN_W(16), .DESCENDING(1'b1)) dut2 (
    .clk(clk), .rst_n(rstN), .start(start2), .run_len(runLen), .busy(busy2),
    .done(done2), .a_empty(a2Empty), .a_data(a2Data), .a_pop(a2Pop),
    .b_empty(b2Empty), .b_data(b2Data), .b_pop(b2Pop), .out_full(out2Full),
    .out_data(out2Data), .out_push(out2Push), .out_count(out2Count));

  int checkCnt = 0;
  int passCnt  = 0;

  logic [7:0] stimA[$], stimB[$], expQ[$];
  logic [7:0] outQ[$], out2Q[$];
  logic       srcQ[$];
  int pushCnt, aPopCnt, bPopCnt, violCnt, stallViol;

  // Monitor sampled on the falling edge: whatever strobes are visible here
  // commit at the next rising edge. Strobe-rule violations are tallied and
  // compared at the end of each test.
  always @(negedge clk) begin
    if (outPush) begin
      outQ.push_back(outData);
      srcQ.push_back(bPop);
      pushCnt++;
    end
    if (aPop) aPopCnt++;
    if (bPop) bPopCnt++;
    if ((aPop && aEmpty) || (bPop && bEmpty) || (aPop && bPop) ||
        (outPush && outFull) || (outPush != (aPop | bPop)))
      violCnt++;
    if ((forceFull || forceBEmpty) && (aPop || bPop || outPush))
      stallViol++;
    if (out2Push) out2Q.push_back(out2Data);
    if ((a2Pop && a2Empty) || (b2Pop && b2Empty) || (a2Pop && b2Pop) ||
        (out2Push && out2Full) || (out2Push != (a2Pop | b2Pop)))
      violCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clearMon();
    outQ.delete(); out2Q.delete(); srcQ.delete();
    pushCnt = 0; aPopCnt = 0; bPopCnt = 0; violCnt = 0; stallViol = 0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #2;
    rstN = 1'b1;
    clearMon();
  endtask

  // Loads stimA/stimB into FIFOs A/B of the chosen controller, one per cycle.
  task automatic applyStimulus(input bit toDut2);
    int n;
    n = (stimA.size() > stimB.size()) ? stimA.size() : stimB.size();
    for (int i = 0; i < n; i++) begin
      tbDataA  = (i < stimA.size()) ? stimA[i] : 8'd0;
      tbDataB  = (i < stimB.size()) ? stimB[i] : 8'd0;
      tbPushA  = !toDut2 && (i < stimA.size());
      tbPushB  = !toDut2 && (i < stimB.size());
      tbPushA2 = toDut2 && (i < stimA.size());
      tbPushB2 = toDut2 && (i < stimB.size());
      @(posedge clk); #1;
    end
    tbPushA = 0; tbPushB = 0; tbPushA2 = 0; tbPushB2 = 0;
  endtask

  task automatic startPulse(input logic [15:0] len, input bit toDut2);
    runLen = len;
    if (toDut2) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  // Counts rising edges until done is seen; also counts busy-high samples.
  task automatic waitDone(input string tag, input bit useDut2,
                          output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = 0;
    while (!(useDut2 ? done2 : done) && cycles < 200) begin
      if (useDut2 ? busy2 : busy) busyCycles++;
      @(posedge clk); #1;
      cycles++;
    end
    if (cycles >= 200) checkOutput({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic waitPushes(input string tag, input int n);
    int guard = 0;
    while (pushCnt < n && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) checkOutput({tag, "_push_timeout"}, pushCnt, n);
  endtask

  task automatic checkSeq(input string tag, input bit useDut2);
    int sz;
    sz = useDut2 ? out2Q.size() : outQ.size();
    checkOutput({tag, "_len"}, sz, expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < sz)
        checkOutput($sformatf("%s_out[%0d]", tag, i),
                    useDut2 ? out2Q[i] : outQ[i], expQ[i]);
    end
  endtask

  int cyc, busyC;

  initial begin
    rstN = 1'b0; start = 0; start2 = 0; runLen = 0;
    forceFull = 0; forceBEmpty = 0;
    tbPushA = 0; tbPushB = 0; tbPushA2 = 0; tbPushB2 = 0;
    tbDataA = 0; tbDataB = 0;
    clearMon();
    @(posedge clk); #1;

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_strobes", {aPop, bPop, outPush}, 0);
    checkOutput("rst_out_data", outData, 0);
    checkOutput("rst_out_count", outCount, 0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_rem", {dut.rem_a_q, dut.rem_b_q}, 0);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Basic ascending merge
    stimA = '{8'd1, 8'd4, 8'd7, 8'd9};
    stimB = '{8'd2, 8'd3, 8'd8, 8'd10};
    applyStimulus(0);
    startPulse(16'd4, 0);
    waitDone("basic", 0, cyc, busyC);
    checkOutput("basic_done_latency", cyc + 1, 9);
    checkOutput("basic_busy_cycles", busyC, 8);
    checkOutput("basic_busy_in_done", busy, 0);
    expQ = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd10};
    checkSeq("basic", 0);
    @(posedge clk); #1;
    checkOutput("basic_done_pulse", done, 0);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("basic_count_hold", outCount, 8);
    checkOutput("basic_viol", violCnt, 0);
    doReset();

    // Ties and stability
    stimA = '{8'd5, 8'd5};
    stimB = '{8'd5, 8'd6};
    applyStimulus(0);
    startPulse(16'd2, 0);
    waitDone("ties", 0, cyc, busyC);
    expQ = '{8'd5, 8'd5, 8'd5, 8'd6};
    checkSeq("ties", 0);
    if (srcQ.size() == 4) begin
      checkOutput("ties_src0_isB", srcQ[0], 0);
      checkOutput("ties_src1_isB", srcQ[1], 0);
      checkOutput("ties_src2_isB", srcQ[2], 1);
      checkOutput("ties_src3_isB", srcQ[3], 1);
    end else checkOutput("ties_src_len", srcQ.size(), 4);
    doReset();

    // Exhaust and drain
    stimA = '{8'd1, 8'd2, 8'd3};
    stimB = '{8'd10, 8'd11, 8'd12};
    applyStimulus(0);
    startPulse(16'd3, 0);
    waitPushes("drain", 3);
    checkOutput("drain_state", 32'(dut.state_q), 32'(DRAIN_B));
    waitDone("drain", 0, cyc, busyC);
    expQ = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd11, 8'd12};
    checkSeq("drain", 0);
    checkOutput("drain_a_pops", aPopCnt, 3);
    checkOutput("drain_b_pops", bPopCnt, 3);
    checkOutput("drain_count", outCount, 6);
    doReset();

    // Back-pressure and starvation
    stimA = '{8'd1, 8'd4, 8'd7, 8'd9};
    stimB = '{8'd2, 8'd3, 8'd8, 8'd10};
    applyStimulus(0);
    startPulse(16'd4, 0);
    waitPushes("bp", 2);
    forceFull = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    forceFull = 1'b0;
    checkOutput("bp_full_pushes", pushCnt, 2);
    waitPushes("bp", 4);
    forceBEmpty = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    forceBEmpty = 1'b0;
    checkOutput("bp_empty_pushes", pushCnt, 4);
    waitDone("bp", 0, cyc, busyC);
    expQ = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd10};
    checkSeq("bp", 0);
    checkOutput("bp_stall_strobes", stallViol, 0);
    checkOutput("bp_viol", violCnt, 0);
    checkOutput("bp_count", outCount, 8);
    doReset();

    // Descending mode
    stimA = '{8'd9, 8'd6};
    stimB = '{8'd8, 8'd2};
    applyStimulus(1);
    startPulse(16'd2, 1);
    waitDone("desc", 1, cyc, busyC);
    expQ = '{8'd9, 8'd8, 8'd6, 8'd2};
    checkSeq("desc", 1);
    checkOutput("desc_count", out2Count, 4);
    checkOutput("desc_viol", violCnt, 0);
    doReset();

    // Zero length
    stimA = '{8'd1};
    stimB = '{8'd2};
    applyStimulus(0);
    startPulse(16'd0, 0);
    waitDone("zero", 0, cyc, busyC);
    checkOutput("zero_done_latency", cyc + 1, 1);
    checkOutput("zero_pops", aPopCnt + bPopCnt, 0);
    checkOutput("zero_count", outCount, 0);
    doReset();

    // Start while busy and start in the DONE cycle are both ignored
    stimA = '{8'd1, 8'd4, 8'd7, 8'd9};
    stimB = '{8'd2, 8'd3, 8'd8, 8'd10};
    applyStimulus(0);
    startPulse(16'd4, 0);
    waitPushes("ign", 2);
    startPulse(16'd1, 0);
    checkOutput("ign_rem_a", dut.rem_a_q, 3);
    checkOutput("ign_rem_b", dut.rem_b_q, 2);
    waitDone("ign", 0, cyc, busyC);
    startPulse(16'd4, 0);
    checkOutput("ign_done_start_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk); #1;
    checkOutput("ign_done_start_busy", busy, 0);
    expQ = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd10};
    checkSeq("ign", 0);
    checkOutput("ign_count", outCount, 8);
    doReset();

    // Asynchronous reset mid-merge
    applyStimulus(0);
    startPulse(16'd4, 0);
    waitPushes("arst", 3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_strobes", {aPop, bPop, outPush}, 0);
    checkOutput("arst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("arst_count", outCount, 0);
    checkOutput("arst_busy", busy, 0);
    #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule : tb_hams_merge_ctrl
